// File: rtl/multicycle_ctrl_if.sv
// Control bus between the instruction register / ALU flags and the multi-cycle datapath muxes and enables.
// Timing: there is no valid/ready pair. Every control output is a combinational function of the current
// state, Instr and the registered flags, and is valid for the whole cycle in which it is presented.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [31:0]        Instr;
  logic [3:0]         ALUFlags;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [STATE_W-1:0] State;

  // Datapath side: supplies the instruction and ALU flags, consumes the controls.
  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
    input  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );

  // Controller side.
  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
    output ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM control unit: sequences fetch/decode/execute/memory/writeback, owns the NZCV
// flags register and evaluates the condition field that gates every architectural write.
module multicycle_ctrl #(
  parameter bit COND_EN = 1'b1,
  parameter int STATE_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t state, next_state;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       funct_i, s_bit, u_bit;
  logic       unused_bits;

  assign cond    = bus.Instr[31:28];
  assign op      = bus.Instr[27:26];
  assign funct_i = bus.Instr[25];
  assign cmd     = bus.Instr[24:21];
  assign s_bit   = bus.Instr[20];
  assign u_bit   = bus.Instr[23];
  assign rd      = bus.Instr[15:12];
  assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  logic [3:0] flags;
  logic       flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  logic [1:0] dp_alu;
  logic       no_write, nz_only;

  always_comb begin
    dp_alu   = 2'b00;
    no_write = 1'b0;
    nz_only  = 1'b0;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: begin dp_alu = 2'b10; nz_only = 1'b1; end
      4'b1100: begin dp_alu = 2'b11; nz_only = 1'b1; end
      4'b1010: begin dp_alu = 2'b01; no_write = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  logic cond_raw, cond_ex;

  always_comb begin
    cond_raw = 1'b0;
    case (cond)
      4'b0000: cond_raw = flag_z;
      4'b0001: cond_raw = ~flag_z;
      4'b0010: cond_raw = flag_c;
      4'b0011: cond_raw = ~flag_c;
      4'b0100: cond_raw = flag_n;
      4'b0101: cond_raw = ~flag_n;
      4'b0110: cond_raw = flag_v;
      4'b0111: cond_raw = ~flag_v;
      4'b1000: cond_raw = flag_c & ~flag_z;
      4'b1001: cond_raw = ~flag_c | flag_z;
      4'b1010: cond_raw = (flag_n == flag_v);
      4'b1011: cond_raw = (flag_n != flag_v);
      4'b1100: cond_raw = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_raw = flag_z | (flag_n != flag_v);
      4'b1110: cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
  end

  assign cond_ex = COND_EN ? cond_raw : 1'b1;

  always_ff @(posedge CLK) begin
    if (!Reset) state <= FETCH;
    else        state <= next_state;
  end

  // Logical ops leave C and V alone; arithmetic ops and CMP overwrite all four flags.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      flags <= 4'b0000;
    end else if ((state == EXECR || state == EXECI) && s_bit && cond_ex) begin
      flags[3:2] <= bus.ALUFlags[3:2];
      if (!nz_only) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  logic       pc_write, mem_write, ir_write, reg_write, adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control;

  always_comb begin
    next_state  = FETCH;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    result_src  = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = funct_i ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b   = 2'b01;
        alu_control = u_bit ? 2'b00 : 2'b01;
        next_state  = s_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src    = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ex;
        pc_write   = cond_ex && (rd == 4'd15);
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
      end
      EXECR: begin
        alu_control = dp_alu;
        next_state  = ALUWB;
      end
      EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = dp_alu;
        next_state  = ALUWB;
      end
      ALUWB: begin
        reg_write = cond_ex && !no_write;
        pc_write  = cond_ex && !no_write && (rd == 4'd15);
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex;
      end
      default: next_state = FETCH;
    endcase
  end

  // Write enables are squashed for the whole reset cycle, independent of state.
  assign bus.PCWrite    = pc_write  & Reset;
  assign bus.MemWrite   = mem_write & Reset;
  assign bus.IRWrite    = ir_write  & Reset;
  assign bus.RegWrite   = reg_write & Reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.State      = STATE_W'(state);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors are queued by the driver
// and checked by an independent negedge monitor.
module tb_multicycle_ctrl;
  logic CLK = 1'b0;
  logic Reset;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

  multicycle_ctrl #(.COND_EN(1'b1), .STATE_W(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_LDR   = 32'hE5910004;
  localparam logic [31:0] I_STR   = 32'hE5010004;
  localparam logic [31:0] I_CMP   = 32'hE1510002;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_BNE   = 32'h1A000002;
  localparam logic [31:0] I_BCS   = 32'h2A000002;
  localparam logic [31:0] I_BVS   = 32'h6A000002;
  localparam logic [31:0] I_BNV   = 32'hFA000002;
  localparam logic [31:0] I_BAL   = 32'hEA000002;
  localparam logic [31:0] I_ANDS  = 32'hE0111002;
  localparam logic [31:0] I_ORRI  = 32'hE3811001;
  localparam logic [31:0] I_ADDPC = 32'hE082F003;
  localparam logic [31:0] I_UND   = 32'hEC000000;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [1:0]  im, rr;

  // Vector layout: State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic rw, input logic [1:0] rs, input logic asa,
      input logic [1:0] asb, input logic [1:0] alc);
    return {st, pcw, adr, mw, irw, rw, rs, asa, asb, alc, im, rr};
  endfunction

  function automatic logic [19:0] v_rst_fetch();       return mk(4'd0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00); endfunction
  function automatic logic [19:0] v_fetch();           return mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00); endfunction
  function automatic logic [19:0] v_decode();          return mk(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00); endfunction
  function automatic logic [19:0] v_memadr(input logic [1:0] alc); return mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, alc); endfunction
  function automatic logic [19:0] v_memrd();           return mk(4'd3, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] v_memwb(input logic rw, input logic pcw); return mk(4'd4, pcw, 0, 0, 0, rw, 2'b01, 0, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] v_memwr(input logic mw); return mk(4'd5, 0, 1, mw, 0, 0, 2'b00, 0, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] v_execr(input logic [1:0] alc); return mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, alc); endfunction
  function automatic logic [19:0] v_execi(input logic [1:0] alc); return mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, alc); endfunction
  function automatic logic [19:0] v_aluwb(input logic rw, input logic pcw); return mk(4'd8, pcw, 0, 0, 0, rw, 2'b00, 0, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] v_branch(input logic pcw); return mk(4'd9, pcw, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00); endfunction

  task automatic cyc(input string nm, input logic rst_n, input logic [31:0] ins,
                     input logic [3:0] fl, input logic [19:0] e);
    Reset        = rst_n;
    bus.Instr    = ins;
    bus.ALUFlags = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_branch(input string nm, input logic [31:0] ins, input logic taken);
    im = 2'b10; rr = 2'b01;
    cyc({nm, "_fetch"},  1'b1, ins, 4'h0, v_fetch());
    cyc({nm, "_decode"}, 1'b1, ins, 4'h0, v_decode());
    cyc({nm, "_branch"}, 1'b1, ins, 4'h0, v_branch(taken));
  endtask

  always @(negedge CLK) begin
    logic [19:0] e, got;
    string       nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
      checks++;
      if (got === e) passes++;
      else $display("FAIL %s: got %05h expected %05h", nm, got, e);
    end
  end

  initial begin
    Reset        = 1'b0;
    bus.Instr    = 32'h0;
    bus.ALUFlags = 4'h0;
    im = 2'b00; rr = 2'b00;
    @(posedge CLK);
    #1;

    // Reset for two cycles, then ADD R1,R2,R3
    cyc("rst0", 1'b0, I_ADD, 4'h0, v_rst_fetch());
    cyc("rst1", 1'b0, I_ADD, 4'h0, v_rst_fetch());
    cyc("add_fetch",  1'b1, I_ADD, 4'h0, v_fetch());
    cyc("add_decode", 1'b1, I_ADD, 4'h0, v_decode());
    cyc("add_execr",  1'b1, I_ADD, 4'hF, v_execr(2'b00));
    cyc("add_aluwb",  1'b1, I_ADD, 4'h0, v_aluwb(1'b1, 1'b0));

    // LDR R0,[R1,#4]
    im = 2'b01; rr = 2'b10;
    cyc("ldr_fetch",  1'b1, I_LDR, 4'h0, v_fetch());
    cyc("ldr_decode", 1'b1, I_LDR, 4'h0, v_decode());
    cyc("ldr_memadr", 1'b1, I_LDR, 4'h0, v_memadr(2'b00));
    cyc("ldr_memrd",  1'b1, I_LDR, 4'h0, v_memrd());
    cyc("ldr_memwb",  1'b1, I_LDR, 4'h0, v_memwb(1'b1, 1'b0));

    // STR with U=0
    cyc("str_fetch",  1'b1, I_STR, 4'h0, v_fetch());
    cyc("str_decode", 1'b1, I_STR, 4'h0, v_decode());
    cyc("str_memadr", 1'b1, I_STR, 4'h0, v_memadr(2'b01));
    cyc("str_memwr",  1'b1, I_STR, 4'h0, v_memwr(1'b1));

    // CMP sets Z, then BEQ taken / BNE not taken
    im = 2'b00; rr = 2'b00;
    cyc("cmp_fetch",  1'b1, I_CMP, 4'h0, v_fetch());
    cyc("cmp_decode", 1'b1, I_CMP, 4'h0, v_decode());
    cyc("cmp_execr",  1'b1, I_CMP, 4'h4, v_execr(2'b01));
    cyc("cmp_aluwb",  1'b1, I_CMP, 4'h0, v_aluwb(1'b0, 1'b0));
    run_branch("beq1", I_BEQ, 1'b1);
    run_branch("bne1", I_BNE, 1'b0);

    // CMP sets C only; ANDS then updates N,Z but must keep C and drop the offered V
    im = 2'b00; rr = 2'b00;
    cyc("cmp2_fetch",  1'b1, I_CMP, 4'h0, v_fetch());
    cyc("cmp2_decode", 1'b1, I_CMP, 4'h0, v_decode());
    cyc("cmp2_execr",  1'b1, I_CMP, 4'h2, v_execr(2'b01));
    cyc("cmp2_aluwb",  1'b1, I_CMP, 4'h0, v_aluwb(1'b0, 1'b0));
    cyc("ands_fetch",  1'b1, I_ANDS, 4'h0, v_fetch());
    cyc("ands_decode", 1'b1, I_ANDS, 4'h0, v_decode());
    cyc("ands_execr",  1'b1, I_ANDS, 4'h5, v_execr(2'b10));
    cyc("ands_aluwb",  1'b1, I_ANDS, 4'h0, v_aluwb(1'b1, 1'b0));
    run_branch("bcs", I_BCS, 1'b1);
    run_branch("bvs", I_BVS, 1'b0);
    run_branch("beq2", I_BEQ, 1'b1);

    // ORR immediate goes through EXECI
    im = 2'b00; rr = 2'b00;
    cyc("orri_fetch",  1'b1, I_ORRI, 4'h0, v_fetch());
    cyc("orri_decode", 1'b1, I_ORRI, 4'h0, v_decode());
    cyc("orri_execi",  1'b1, I_ORRI, 4'hF, v_execi(2'b11));
    cyc("orri_aluwb",  1'b1, I_ORRI, 4'h0, v_aluwb(1'b1, 1'b0));

    // ADD PC,R2,R3 writes the register file and the PC together; S=0 leaves flags intact
    cyc("addpc_fetch",  1'b1, I_ADDPC, 4'h0, v_fetch());
    cyc("addpc_decode", 1'b1, I_ADDPC, 4'h0, v_decode());
    cyc("addpc_execr",  1'b1, I_ADDPC, 4'h0, v_execr(2'b00));
    cyc("addpc_aluwb",  1'b1, I_ADDPC, 4'h0, v_aluwb(1'b1, 1'b1));
    run_branch("beq3", I_BEQ, 1'b1);

    // Reset during MEMWR of STR squashes the write and clears flags
    im = 2'b01; rr = 2'b10;
    cyc("str2_fetch",  1'b1, I_STR, 4'h0, v_fetch());
    cyc("str2_decode", 1'b1, I_STR, 4'h0, v_decode());
    cyc("str2_memadr", 1'b1, I_STR, 4'h0, v_memadr(2'b01));
    cyc("str2_memwr_rst", 1'b0, I_STR, 4'h0, v_memwr(1'b0));

    // Undefined Op=11: FETCH, DECODE, back to FETCH
    im = 2'b11; rr = 2'b00;
    cyc("und_fetch",  1'b1, I_UND, 4'h0, v_fetch());
    cyc("und_decode", 1'b1, I_UND, 4'h0, v_decode());
    run_branch("beq_after_rst", I_BEQ, 1'b0);
    run_branch("bnv", I_BNV, 1'b0);
    run_branch("bal", I_BAL, 1'b1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
